selftrigger_baseline_holdoff: RTL and testbench
===============================================

// Module: selftrigger_baseline_holdoff
// PURPOSE
// Parametrised single-channel self-trigger for the DAPHNE filtering chain. Tracks the
// pedestal with a k-shift IIR baseline that freezes during pulses, thresholds the
// baseline-subtracted signal with hysteresis and a holdoff window, and reports peak
// amplitude and time-over-threshold per trigger. Sits after the AFE sample path,
// ahead of the frame builder; one instance per channel.
// PARAMETERS
// W         14   input sample width (signed)
// K         6    baseline IIR shift; time constant 2^K samples
// HOLD_W    10   width of holdoff counter/config
// CNT_W     16   width of time-over-threshold and trigger counters
// PORTS
// clk          in   1       system clock
// reset_n      in   1       reset, synchronous, active-low
// enable       in   1       1 = triggering active; 0 = bypass
// polarity     in   1       0 = positive pulses (x-baseline), 1 = negative (baseline-x)
// threshold    in   W       unsigned trigger level on pulse signal
// hysteresis   in   W       re-arm margin below threshold
// holdoff      in   HOLD_W  dead cycles after pulse end
// x            in   W       signed sample, one per clk
// y            out  W       signed x-baseline, saturated
// baseline     out  W       signed current pedestal estimate
// trigger      out  1       one-cycle pulse on threshold crossing
// busy         out  1       high in TRIG or HOLD
// peak_valid   out  1       one-cycle pulse at pulse end
// peak_value   out  W       max pulse signal over the pulse, saturated unsigned
// tot          out  CNT_W   cycles spent in TRIG, saturating
// trig_count   out  CNT_W   triggers since reset, saturating
// BEHAVIOUR
// - Reset (reset_n=0 at edge): state=INIT, acc=0, all outputs 0.
// - Baseline: acc is (W+K) signed; baseline=acc>>>K. In INIT acc<=x<<K (fast pedestal
//   load), then ARM. In ARM: acc<=acc+x-baseline. In TRIG/HOLD acc frozen.
// - Pulse signal s = polarity ? baseline-x : x-baseline, computed W+1 bits, no wrap.
// - y = saturate_W(x-baseline) registered, latency 1; enable=0 -> y=x (registered).
// - FSM (registered, evaluates current x):
//   INIT -> ARM unconditionally after 1 cycle.
//   ARM  -> TRIG when enable && s>=threshold; latch thr_l=threshold,
//           rearm_l = max(threshold-hysteresis,0); trigger=1 next cycle.
//   TRIG -> HOLD when s<rearm_l; peak_valid=1 next cycle with peak_value, tot.
//           holdoff=0: TRIG -> ARM directly (no HOLD cycle).
//   HOLD -> ARM after exactly holdoff cycles in HOLD.
// - Threshold/hysteresis/holdoff changes mid-pulse ignored until next ARM (latched).
// - enable falling in TRIG/HOLD: finish current pulse/holdoff normally; no new triggers
//   while enable=0; baseline keeps tracking in ARM.
// - threshold=0: any s>=0 triggers; that is legal, not blocked.
// - peak: max s over TRIG cycles including entry sample; tot counts TRIG cycles,
//   saturates at 2^CNT_W-1; trig_count increments on each trigger, saturates.
// - Simultaneous: exit condition and rearm in same cycle not possible (HOLD >= 1 cycle
//   when holdoff>0). Reset overrides everything, including mid-pulse.
// - Latency: sample at edge n crossing threshold -> trigger high cycle n+1.
// TESTING
// W=14,K=6, threshold=100, hysteresis=20, holdoff=64, polarity=0 unless stated.
// 1 Reset then x=8000 const 200 cycles -> baseline=8000 after 1st sample, y=0, no trigger.
// 2 Step x=8000->8150 for 10 cycles ->1 trigger pulse, busy 10+64 cycles, peak=150,
//   tot=10, baseline stays 8000 through pulse, trig_count=1.
// 3 x=8000+{120,90,85,70} -> stays TRIG at 90,85 (>=80), exits at 70; tot=3, peak=120.
// 4 polarity=1, x=8000->7850 for 5 -> trigger, peak=150; positive 8150 step -> none.
// 5 Second pulse during HOLD -> no trigger; pulse after HOLD -> trigger, count=2.
// 6 reset_n=0 mid-TRIG -> next cycle all outputs 0, state INIT, baseline reloads.

Source files
------------

// File: rtl/selftrigger_baseline_holdoff_if.sv
// Per-channel bundle: sample and configuration in, filtered sample and trigger reports out.
interface selftrigger_baseline_holdoff_if #(
    parameter int W      = 14,
    parameter int HOLD_W = 10,
    parameter int CNT_W  = 16
);
    logic                enable;
    logic                polarity;
    logic [W-1:0]        threshold;
    logic [W-1:0]        hysteresis;
    logic [HOLD_W-1:0]   holdoff;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] baseline;
    logic                trigger;
    logic                busy;
    logic                peak_valid;
    logic [W-1:0]        peak_value;
    logic [CNT_W-1:0]    tot;
    logic [CNT_W-1:0]    trig_count;

    modport master (
        output enable, polarity, threshold, hysteresis, holdoff, x,
        input  y, baseline, trigger, busy, peak_valid, peak_value, tot, trig_count
    );
    modport slave (
        input  enable, polarity, threshold, hysteresis, holdoff, x,
        output y, baseline, trigger, busy, peak_valid, peak_value, tot, trig_count
    );
endinterface

// File: rtl/selftrigger_baseline_holdoff.sv
// Single-channel self-trigger: frozen-during-pulse IIR baseline, hysteresis threshold,
// holdoff window, and per-pulse peak / time-over-threshold reporting.
module selftrigger_baseline_holdoff #(
    parameter int W      = 14,
    parameter int K      = 6,
    parameter int HOLD_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    selftrigger_baseline_holdoff_if.slave bus
);
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_ARM  = 2'd1,
        ST_TRIG = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_ONE = {{(HOLD_W-1){1'b0}}, 1'b1};

    function automatic logic signed [W-1:0] sat_s(input logic signed [W:0] v);
        logic signed [W-1:0] r;
        if (v[W] != v[W-1]) r = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else                r = v[W-1:0];
        return r;
    endfunction

    function automatic logic [W-1:0] sat_u(input logic signed [W:0] v);
        logic [W-1:0] r;
        if (v[W]) r = {W{1'b0}};
        else      r = v[W-1:0];
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) r = v;
        else                    r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        return r;
    endfunction

    state_t                state_r, state_nx_s;
    logic signed [W+K-1:0] acc_r;
    logic signed [W-1:0]   base_s;
    logic signed [W:0]     diff_s, sig_s;
    logic                  ge_thr_s, below_rearm_s, fire_s, end_s;
    logic [W-1:0]          rearm_s, rearm_l_r;
    logic [HOLD_W-1:0]     hold_l_r, hold_cnt_r;
    logic signed [W-1:0]   y_r;
    logic                  trigger_r, busy_r, peak_valid_r;
    logic [W-1:0]          peak_run_r, peak_value_r;
    logic [CNT_W-1:0]      tot_run_r, tot_r, trig_count_r;

    assign base_s        = acc_r[W+K-1:K];
    assign diff_s        = {bus.x[W-1], bus.x} - {base_s[W-1], base_s};
    assign ge_thr_s      = (sig_s >= $signed({1'b0, bus.threshold}));
    assign below_rearm_s = (sig_s < $signed({1'b0, rearm_l_r}));
    assign rearm_s       = (bus.threshold > bus.hysteresis) ? (bus.threshold - bus.hysteresis)
                                                            : {W{1'b0}};

    // Pulse signal in the selected polarity; W+1 bits so it never wraps.
    always_comb begin
        sig_s = diff_s;
        if (bus.polarity) sig_s = -diff_s;
        else              sig_s = diff_s;
    end

    // Next-state decode plus the one-cycle trigger-fire and pulse-end strobes.
    always_comb begin
        state_nx_s = state_r;
        fire_s     = 1'b0;
        end_s      = 1'b0;
        case (state_r)
            ST_INIT: state_nx_s = ST_ARM;
            ST_ARM: begin
                if (bus.enable && ge_thr_s) begin
                    fire_s     = 1'b1;
                    state_nx_s = ST_TRIG;
                end else begin
                    state_nx_s = ST_ARM;
                end
            end
            ST_TRIG: begin
                if (below_rearm_s) begin
                    end_s = 1'b1;
                    if (hold_l_r == {HOLD_W{1'b0}}) state_nx_s = ST_ARM;
                    else                            state_nx_s = ST_HOLD;
                end else begin
                    state_nx_s = ST_TRIG;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_r == hold_l_r - HOLD_ONE) state_nx_s = ST_ARM;
                else                                   state_nx_s = ST_HOLD;
            end
            default: state_nx_s = ST_INIT;
        endcase
    end

    // State, baseline accumulator, latched pulse config and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_INIT;
            acc_r        <= {(W+K){1'b0}};
            rearm_l_r    <= {W{1'b0}};
            hold_l_r     <= {HOLD_W{1'b0}};
            hold_cnt_r   <= {HOLD_W{1'b0}};
            y_r          <= {W{1'b0}};
            trigger_r    <= 1'b0;
            busy_r       <= 1'b0;
            peak_valid_r <= 1'b0;
            peak_run_r   <= {W{1'b0}};
            peak_value_r <= {W{1'b0}};
            tot_run_r    <= {CNT_W{1'b0}};
            tot_r        <= {CNT_W{1'b0}};
            trig_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nx_s;
            y_r          <= bus.enable ? sat_s(diff_s) : bus.x;
            trigger_r    <= fire_s;
            peak_valid_r <= end_s;
            busy_r       <= (state_nx_s == ST_TRIG) || (state_nx_s == ST_HOLD);
            case (state_r)
                ST_INIT: acc_r <= {bus.x, {K{1'b0}}};
                ST_ARM: begin
                    // The crossing sample belongs to the pulse, so it must not leak into the pedestal.
                    if (fire_s) begin
                        rearm_l_r    <= rearm_s;
                        hold_l_r     <= bus.holdoff;
                        peak_run_r   <= sat_u(sig_s);
                        tot_run_r    <= {CNT_W{1'b0}};
                        trig_count_r <= inc_sat(trig_count_r);
                    end else begin
                        acc_r <= acc_r + {{(K-1){diff_s[W]}}, diff_s};
                    end
                end
                ST_TRIG: begin
                    tot_run_r <= inc_sat(tot_run_r);
                    if (sig_s > $signed({1'b0, peak_run_r})) peak_run_r <= sat_u(sig_s);
                    if (end_s) begin
                        peak_value_r <= peak_run_r;
                        tot_r        <= inc_sat(tot_run_r);
                        hold_cnt_r   <= {HOLD_W{1'b0}};
                    end
                end
                ST_HOLD: hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                default: acc_r <= acc_r;
            endcase
        end
    end

    assign bus.y          = y_r;
    assign bus.baseline   = base_s;
    assign bus.trigger    = trigger_r;
    assign bus.busy       = busy_r;
    assign bus.peak_valid = peak_valid_r;
    assign bus.peak_value = peak_value_r;
    assign bus.tot        = tot_r;
    assign bus.trig_count = trig_count_r;
endmodule

// File: tb/tb_selftrigger_baseline_holdoff.sv
// Directed bench for the self-trigger: per-cycle comparison against a behavioural
// pulse/holdoff model, plus hand-computed expectations for each scenario.
module tb_selftrigger_baseline_holdoff;
    localparam int     W       = 14;
    localparam int     K       = 6;
    localparam int     HOLD_W  = 10;
    localparam int     CNT_W   = 16;
    localparam longint CNT_MAX = 65535;
    localparam longint Y_MAX   = 8191;
    localparam longint Y_MIN   = -8192;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    selftrigger_baseline_holdoff_if #(.W(W), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) bus ();
    selftrigger_baseline_holdoff #(.W(W), .K(K), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_trig = 0;
    int n_busy = 0;
    int n_pv   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d at t=%0t", name, act, exp, $time);
    endtask

    function automatic longint clip(input longint v);
        if (v > Y_MAX) return Y_MAX;
        if (v < Y_MIN) return Y_MIN;
        return v;
    endfunction

    // Behavioural model: pedestal integer, pulse flag and remaining dead cycles.
    longint m_acc, m_rearm, m_peak, m_tot, m_cnt;
    bit     m_loaded, m_pulse, m_seen;
    int     m_hold, m_hold_len;
    longint e_y, e_base, e_peak, e_tot;
    bit     e_trig, e_busy, e_pv;

    initial m_seen = 1'b0;

    always @(posedge clk) begin : model
        longint xv, bl, d, s, thr, hys;
        xv     = longint'(bus.x);
        thr    = longint'(bus.threshold);
        hys    = longint'(bus.hysteresis);
        m_seen = 1'b1;
        e_trig = 1'b0;
        e_pv   = 1'b0;
        if (!reset_n) begin
            m_acc = 0; m_loaded = 0; m_pulse = 0; m_hold = 0; m_cnt = 0;
            m_peak = 0; m_tot = 0; e_y = 0; e_peak = 0; e_tot = 0;
        end else begin
            bl  = m_acc >>> K;
            d   = xv - bl;
            s   = bus.polarity ? (bl - xv) : d;
            e_y = bus.enable ? clip(d) : xv;
            if (!m_loaded) begin
                m_acc    = xv * (64'sd1 <<< K);
                m_loaded = 1'b1;
            end else if (m_pulse) begin
                if (m_tot < CNT_MAX) m_tot++;
                if (s > m_peak) m_peak = s;
                if (s < m_rearm) begin
                    m_pulse = 1'b0;
                    e_pv    = 1'b1;
                    e_peak  = m_peak;
                    e_tot   = m_tot;
                    m_hold  = m_hold_len;
                end
            end else if (m_hold > 0) begin
                m_hold--;
            end else if (bus.enable && s >= thr) begin
                m_pulse    = 1'b1;
                e_trig     = 1'b1;
                m_peak     = s;
                m_tot      = 0;
                m_rearm    = (thr > hys) ? thr - hys : 0;
                m_hold_len = int'(bus.holdoff);
                if (m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m_acc = m_acc + d;
            end
        end
        e_busy = m_pulse || (m_hold > 0);
        e_base = m_acc >>> K;
    end

    always @(negedge clk) begin
        if (m_seen) begin
            chk("y",          longint'(bus.y),          e_y);
            chk("baseline",   longint'(bus.baseline),   e_base);
            chk("trigger",    longint'(bus.trigger),    longint'(e_trig));
            chk("busy",       longint'(bus.busy),       longint'(e_busy));
            chk("peak_valid", longint'(bus.peak_valid), longint'(e_pv));
            chk("peak_value", longint'(bus.peak_value), e_peak);
            chk("tot",        longint'(bus.tot),        e_tot);
            chk("trig_count", longint'(bus.trig_count), m_cnt);
            if (bus.trigger === 1'b1)    n_trig++;
            if (bus.busy === 1'b1)       n_busy++;
            if (bus.peak_valid === 1'b1) n_pv++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int t0, b0, p0;
        reset_n        = 1'b0;
        bus.enable     = 1'b1;
        bus.polarity   = 1'b0;
        bus.threshold  = 14'd100;
        bus.hysteresis = 14'd20;
        bus.holdoff    = 10'd64;
        bus.x          = 14'sd0;
        cyc(3);

        // Pedestal load and steady state
        reset_n = 1'b1;
        bus.x   = 14'sd8000;
        cyc(1);
        chk("lit_base_first", longint'(bus.baseline), 8000);
        cyc(199);
        chk("lit_base_steady", longint'(bus.baseline), 8000);
        chk("lit_y_steady", longint'(bus.y), 0);
        chk("lit_count0", longint'(bus.trig_count), 0);

        // 10-sample step: one trigger, 10 TRIG + 64 HOLD busy cycles
        t0 = n_trig; b0 = n_busy; p0 = n_pv;
        bus.x = 14'sd8150; cyc(10);
        bus.x = 14'sd8000; cyc(80);
        chk("lit_step_trig", n_trig - t0, 1);
        chk("lit_step_busy", n_busy - b0, 74);
        chk("lit_step_pv", n_pv - p0, 1);
        chk("lit_step_peak", longint'(bus.peak_value), 150);
        chk("lit_step_tot", longint'(bus.tot), 10);
        chk("lit_step_base", longint'(bus.baseline), 8000);
        chk("lit_step_count", longint'(bus.trig_count), 1);

        // Hysteresis: stays in TRIG at 90 and 85, exits at 70
        b0 = n_busy;
        bus.x = 14'sd8120; cyc(1);
        bus.x = 14'sd8090; cyc(1);
        bus.x = 14'sd8085; cyc(1);
        bus.x = 14'sd8070; cyc(1);
        bus.x = 14'sd8000; cyc(70);
        chk("lit_hyst_tot", longint'(bus.tot), 3);
        chk("lit_hyst_peak", longint'(bus.peak_value), 120);
        chk("lit_hyst_busy", n_busy - b0, 67);
        chk("lit_hyst_count", longint'(bus.trig_count), 2);

        // Zero threshold triggers on s=0; threshold/holdoff edits after entry are ignored
        t0 = n_trig; b0 = n_busy;
        bus.threshold = 14'd0;
        bus.holdoff   = 10'd4;
        cyc(1);
        bus.threshold = 14'd100;
        bus.holdoff   = 10'd64;
        cyc(1);
        bus.x = 14'sd7990; cyc(1);
        bus.x = 14'sd8000; cyc(10);
        chk("lit_thr0_trig", n_trig - t0, 1);
        chk("lit_thr0_busy", n_busy - b0, 6);
        chk("lit_thr0_peak", longint'(bus.peak_value), 0);
        chk("lit_thr0_tot", longint'(bus.tot), 2);

        // Negative polarity pulse, then a positive step that must not trigger
        bus.polarity = 1'b1;
        t0 = n_trig;
        bus.x = 14'sd7850; cyc(5);
        bus.x = 14'sd8000; cyc(70);
        chk("lit_neg_peak", longint'(bus.peak_value), 150);
        chk("lit_neg_tot", longint'(bus.tot), 5);
        chk("lit_neg_trig", n_trig - t0, 1);
        t0 = n_trig;
        bus.x = 14'sd8150; cyc(10);
        bus.x = 14'sd8000; cyc(300);
        chk("lit_neg_posstep", n_trig - t0, 0);
        bus.polarity = 1'b0;

        // Pulse inside HOLD is ignored, pulse after HOLD triggers
        t0 = n_trig;
        bus.x = 14'sd8150; cyc(5);
        bus.x = 14'sd8000; cyc(10);
        bus.x = 14'sd8150; cyc(5);
        bus.x = 14'sd8000; cyc(60);
        bus.x = 14'sd8150; cyc(5);
        bus.x = 14'sd8000; cyc(70);
        chk("lit_hold_trig", n_trig - t0, 2);
        chk("lit_hold_count", longint'(bus.trig_count), 6);

        // holdoff=0 returns straight to ARM; mid-pulse holdoff change ignored
        b0 = n_busy;
        bus.holdoff = 10'd0;
        bus.x = 14'sd8150; cyc(1);
        bus.holdoff = 10'd64;
        cyc(2);
        bus.x = 14'sd8000; cyc(5);
        chk("lit_h0_busy", n_busy - b0, 3);
        chk("lit_h0_tot", longint'(bus.tot), 3);
        chk("lit_h0_count", longint'(bus.trig_count), 7);

        // Bypass: y follows x, no triggers
        t0 = n_trig;
        bus.enable = 1'b0;
        bus.x = 14'sd8150; cyc(5);
        chk("lit_bypass_y", longint'(bus.y), 8150);
        chk("lit_bypass_trig", n_trig - t0, 0);
        bus.enable = 1'b1;
        bus.x = 14'sd8000; cyc(300);

        // Reset in the middle of a pulse
        bus.x = 14'sd8150; cyc(3);
        chk("lit_rst_pre_busy", longint'(bus.busy), 1);
        reset_n = 1'b0; cyc(1);
        chk("lit_rst_y", longint'(bus.y), 0);
        chk("lit_rst_base", longint'(bus.baseline), 0);
        chk("lit_rst_busy", longint'(bus.busy), 0);
        chk("lit_rst_trigger", longint'(bus.trigger), 0);
        chk("lit_rst_pv", longint'(bus.peak_valid), 0);
        chk("lit_rst_peak", longint'(bus.peak_value), 0);
        chk("lit_rst_tot", longint'(bus.tot), 0);
        chk("lit_rst_count", longint'(bus.trig_count), 0);
        reset_n = 1'b1;
        t0 = n_trig;
        cyc(1);
        chk("lit_reload_base", longint'(bus.baseline), 8150);
        cyc(5);
        chk("lit_reload_trig", n_trig - t0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
